// File: rtl/keccak_job_arbiter.sv
// Purpose     : shares one pipeline_top Keccak core between NREQ hash requesters, round-robin.
// Latency     : grant 1 cycle after req_vld seen in IDLE, core_start 1 cycle later; data/digest paths are combinational.
// Backpressure: the core paces the message with core_valid (mirrored on req_rdy); a non-owner request waits while busy.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset (core shares it)
//   req_vld/cmode/d/dt/last        per-requester job request, mode, SHAKE length, message word, last_block
//   req_grant, req_rdy             one-hot grant pulse, one-hot "word consumed"
//   rsp_vld, rsp_dt, rsp_done      one-hot digest strobe, shared digest bus, one-hot final-word pulse
//   core_*                         connection to pipeline_top (start, cmode, d, dt_i, last_block, valid, finish, hash)
//   busy, owner, err_tmo           job in flight, current/last granted index, sticky watchdog flag
//
// Optional: define KECCAK_ARB_TIMEOUT_EN to add a TMO_CYC-cycle watchdog that aborts a hung job.

module keccak_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TMO_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [3*NREQ-1:0]    req_cmode,
  input  logic [11*NREQ-1:0]   req_d,
  input  logic [64*NREQ-1:0]   req_dt,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_grant,
  output logic [NREQ-1:0]      req_rdy,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [31:0]          rsp_dt,
  output logic [NREQ-1:0]      rsp_done,
  output logic                 core_start,
  output logic [2:0]           core_cmode,
  output logic [10:0]          core_d,
  output logic [63:0]          core_dt,
  output logic                 core_last,
  input  logic                 core_valid,
  input  logic                 core_finish,
  input  logic [31:0]          core_hash,
  output logic                 busy,
  output logic [IDW-1:0]       owner,
  output logic                 err_tmo
);

  // Elaboration-time guard: the arbiter supports 2..8 requesters and the
  // watchdog counter is 16 bits wide.
  if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_cfg
    $error("keccak_job_arbiter: NREQ must be 2..8 and TMO_CYC 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_NOJOB,    // zero-word job: report done without touching the core
    S_START,
    S_ABSORB,
    S_SQUEEZE
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  owner_q;
  logic [2:0]      cmode_q;
  logic [10:0]     d_q;
  logic [5:0]      words_q;
  logic [5:0]      cnt_q;
  logic            last_seen_q;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  cand;
  int              sel_j;
  logic [11:0]     deff;
  logic [5:0]      w_calc;
  logic            rsp_word;
  logic            job_end;
  logic [IDW-1:0]  nxt_rr;
  logic            tmo_hit;

  // Per-requester views of the flat input buses.
  logic [2:0]  cm_arr [NREQ];
  logic [10:0] d_arr  [NREQ];
  logic [63:0] dt_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cm_arr[g] = req_cmode[3*g +: 3];
    assign d_arr[g]  = req_d[11*g +: 11];
    assign dt_arr[g] = req_dt[64*g +: 64];
  end

  // Round-robin pick: first requester at or after rr_q, wrapping.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    sel_j    = 0;
    cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_j = int'(rr_q) + i;
      if (sel_j >= NREQ) sel_j = sel_j - NREQ;
      cand = IDW'(sel_j);
      if (!pick_any && req_vld[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Digest word count from the latched mode. Modes 6/7 map to zero words.
  always_comb begin
    deff = '0;
    case (cmode_q)
      3'd0:       deff = 12'd224;
      3'd1:       deff = 12'd256;
      3'd2:       deff = 12'd384;
      3'd3:       deff = 12'd512;
      3'd4, 3'd5: deff = {1'b0, d_q};
      default:    deff = '0;
    endcase
  end

  // deff <= 1600 is guaranteed by the core, so the count fits in 6 bits.
  assign w_calc = 6'((deff + 12'd31) >> 5);

  assign nxt_rr = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    req_grant  = '0;
    req_rdy    = '0;
    rsp_vld    = '0;
    rsp_done   = '0;
    rsp_dt     = '0;
    core_start = 1'b0;
    core_dt    = '0;
    core_last  = 1'b0;
    rsp_word   = 1'b0;
    job_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_any) state_d = S_GRANT;
      end
      S_GRANT: begin
        req_grant[owner_q] = 1'b1;
        state_d = (w_calc == 6'd0) ? S_NOJOB : S_START;
      end
      S_NOJOB: begin
        rsp_done[owner_q] = 1'b1;
        job_end = 1'b1;
        state_d = S_IDLE;
      end
      S_START: begin
        core_start = 1'b1;
        state_d = S_ABSORB;
      end
      S_ABSORB: begin
        core_dt   = dt_arr[owner_q];
        core_last = req_last[owner_q];
        req_rdy[owner_q] = core_valid;
        // The core may still be consuming padding after the last word; wait
        // for core_valid to drop before squeezing.
        if (last_seen_q && !core_valid) state_d = S_SQUEEZE;
      end
      S_SQUEEZE: begin
        if (core_finish) begin
          rsp_word = 1'b1;
          rsp_vld[owner_q] = 1'b1;
          rsp_dt = core_hash;
          if (cnt_q + 6'd1 == words_q) begin
            rsp_done[owner_q] = 1'b1;
            job_end = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog abort: report done with no data and free the core.
    if (tmo_hit) begin
      rsp_vld  = '0;
      rsp_dt   = '0;
      rsp_word = 1'b0;
      req_rdy  = '0;
      rsp_done = '0;
      rsp_done[owner_q] = 1'b1;
      job_end  = 1'b1;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      cmode_q     <= '0;
      d_q         <= '0;
      words_q     <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pick_any) begin
        owner_q <= pick_idx;
        cmode_q <= cm_arr[pick_idx];
        d_q     <= d_arr[pick_idx];
      end
      if (state_q == S_GRANT) begin
        words_q     <= w_calc;
        cnt_q       <= '0;
        last_seen_q <= 1'b0;
      end
      if (state_q == S_ABSORB && core_valid && req_last[owner_q]) last_seen_q <= 1'b1;
      if (rsp_word) cnt_q <= cnt_q + 6'd1;
      if (job_end) rr_q <= nxt_rr;
    end
  end

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC);

  logic [15:0] tmo_cnt_q;
  logic        err_tmo_q;

  // Counter only fires outside IDLE; any state change or core activity
  // proves the job is still alive.
  assign tmo_hit = (state_q != S_IDLE) && (tmo_cnt_q == TMO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      if (state_d != state_q || core_valid || core_finish) tmo_cnt_q <= '0;
      else if (tmo_cnt_q != TMO_LIM) tmo_cnt_q <= tmo_cnt_q + 16'd1;
      if (tmo_hit) err_tmo_q <= 1'b1;
    end
  end

  assign err_tmo = err_tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;
  assign core_cmode = busy ? cmode_q : '0;
  assign core_d     = busy ? d_q : '0;

endmodule

// File: tb/tb_keccak_job_arbiter.sv
module tb_keccak_job_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_vld;
  logic [3*NREQ-1:0]   req_cmode;
  logic [11*NREQ-1:0]  req_d;
  logic [64*NREQ-1:0]  req_dt;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_grant, req_rdy, rsp_vld, rsp_done;
  logic [31:0]         rsp_dt;
  logic                core_start;
  logic [2:0]          core_cmode;
  logic [10:0]         core_d;
  logic [63:0]         core_dt;
  logic                core_last;
  logic                core_valid, core_finish;
  logic [31:0]         core_hash;
  logic                busy;
  logic [IDW-1:0]      owner;
  logic                err_tmo;

  keccak_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .TMO_CYC(4096)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_cmode(req_cmode), .req_d(req_d), .req_dt(req_dt),
    .req_last(req_last), .req_grant(req_grant), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_dt(rsp_dt), .rsp_done(rsp_done),
    .core_start(core_start), .core_cmode(core_cmode), .core_d(core_d),
    .core_dt(core_dt), .core_last(core_last), .core_valid(core_valid),
    .core_finish(core_finish), .core_hash(core_hash),
    .busy(busy), .owner(owner), .err_tmo(err_tmo)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int rr_m   = 0;   // reference round-robin pointer

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference rules: digest words = ceil(bits/32); SHAKE uses d; 6/7 are empty jobs.
  function automatic int words_for(input int cm, input int d);
    int bits;
    case (cm)
      0: bits = 224;
      1: bits = 256;
      2: bits = 384;
      3: bits = 512;
      4, 5: bits = d;
      default: bits = 0;
    endcase
    return (bits + 31) / 32;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] pend);
    for (int k = 0; k < NREQ; k++)
      if (pend[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int r, input int cm, input int d);
    req_cmode[3*r +: 3] = 3'(cm);
    req_d[11*r +: 11]   = 11'(d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, req_grant, 0);
    check({tag, "_rdy"}, req_rdy, 0);
    check({tag, "_rsp_vld"}, rsp_vld, 0);
    check({tag, "_rsp_dt"}, rsp_dt, 0);
    check({tag, "_rsp_done"}, rsp_done, 0);
    check({tag, "_start"}, core_start, 0);
    check({tag, "_cmode"}, core_cmode, 0);
    check({tag, "_d"}, core_d, 0);
    check({tag, "_core_dt"}, core_dt, 0);
    check({tag, "_core_last"}, core_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_err_tmo"}, err_tmo, 0);
  endtask

  // Runs one job from an IDLE cycle; acts as requester and as the core.
  // abort_after >= 0 returns mid-squeeze after that many digest words.
  task automatic serve(input int nwords, input int abort_after, output int w);
    int wexp, cm, dl;
    logic [63:0] wd;
    logic [31:0] hv;
    core_valid  = 1'b0;
    core_finish = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    w = pick(req_vld);
    if (w < 0) begin
      $display("FAIL serve: no request pending");
      $fatal(1);
    end
    cm   = int'(req_cmode[3*w +: 3]);
    dl   = int'(req_d[11*w +: 11]);
    wexp = words_for(cm, dl);
    step();
    req_vld[w] = 1'b0;
    @(negedge clk);
    check("grant", req_grant, 64'(1 << w));
    check("owner", owner, 64'(w));
    check("grant_busy", busy, 1);
    step();
    if (wexp == 0) begin
      @(negedge clk);
      check("nojob_done", rsp_done, 64'(1 << w));
      check("nojob_start", core_start, 0);
      step();
      rr_m = (w + 1) % NREQ;
      return;
    end
    @(negedge clk);
    check("start", core_start, 1);
    check("core_cmode", core_cmode, 64'(cm));
    check("core_d", core_d, 64'(dl));
    step();
    for (int k = 0; k < nwords; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        core_valid  = 1'b0;
        core_finish = 1'($urandom_range(0, 1));
        core_hash   = $urandom;
        @(negedge clk);
        check("absorb_gap_rdy", req_rdy, 0);
        check("absorb_gap_rsp", rsp_vld, 0);
        step();
        core_finish = 1'b0;
      end
      wd = {$urandom, $urandom};
      req_dt[64*w +: 64] = wd;
      req_last[w] = (k == nwords - 1);
      core_valid = 1'b1;
      @(negedge clk);
      check("core_dt", core_dt, wd);
      check("core_last", core_last, 64'(k == nwords - 1));
      check("req_rdy", req_rdy, 64'(1 << w));
      step();
    end
    core_valid  = 1'b0;
    req_last[w] = 1'b0;
    @(negedge clk);
    check("absorb_tail_rdy", req_rdy, 0);
    step();
    for (int k = 0; k < wexp; k++) begin
      if (k == abort_after) return;
      if ($urandom_range(0, 2) == 0) begin
        core_finish = 1'b0;
        @(negedge clk);
        check("squeeze_gap_vld", rsp_vld, 0);
        check("squeeze_busy", busy, 1);
        step();
      end
      hv = $urandom;
      core_hash   = hv;
      core_finish = 1'b1;
      @(negedge clk);
      check("rsp_vld", rsp_vld, 64'(1 << w));
      check("rsp_dt", rsp_dt, 64'(hv));
      check("rsp_done", rsp_done, (k == wexp - 1) ? 64'(1 << w) : 64'd0);
      check("squeeze_busy", busy, 1);
      step();
    end
    core_finish = 1'b0;
    rr_m = (w + 1) % NREQ;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [NREQ-1:0] fresh;
    rst = 1'b1;
    req_vld = '0; req_cmode = '0; req_d = '0; req_dt = '0; req_last = '0;
    core_valid = 1'b0; core_finish = 1'b0; core_hash = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    step();

    // All four requesting, held: expect 0,1,2,3,0 with no overlap.
    for (int r = 0; r < NREQ; r++) set_job(r, $urandom_range(0, 7), $urandom_range(0, 300));
    for (int j = 0; j < 5; j++) begin
      req_vld = '1;
      serve($urandom_range(1, 3), -1, w);
    end
    req_vld = '0;

    // SHA3-256 from requester 2, one 17-word block.
    set_job(2, 1, 0);
    req_vld = 4'b0100;
    serve(17, -1, w);

    // SHAKE128 d=100: four words, a fifth finish must be ignored.
    set_job(0, 4, 100);
    req_vld = 4'b0001;
    serve(2, -1, w);
    core_finish = 1'b1;
    core_hash = $urandom;
    @(negedge clk);
    check("extra_finish_vld", rsp_vld, 0);
    check("extra_finish_done", rsp_done, 0);
    step();
    core_finish = 1'b0;

    // Empty job (cmode 7) from requester 1.
    set_job(1, 7, 0);
    req_vld = 4'b0010;
    serve(1, -1, w);
    @(negedge clk);
    check("nojob_after_busy", busy, 0);
    step();

    // Reset mid-squeeze after three words; pending requests restart from 0.
    set_job(2, 3, 0);
    req_vld = 4'b0100;
    serve(2, 3, w);
    rst = 1'b1;
    core_finish = 1'b0;
    step();
    rst = 1'b0;
    rr_m = 0;
    @(negedge clk);
    check_zero("midjob_rst");
    step();
    set_job(1, 2, 0);
    set_job(3, 5, 64);
    req_vld = 4'b1010;
    serve(1, -1, w);
    serve(2, -1, w);

    // Random traffic; requests stay pending until granted.
    req_vld = '0;
    for (int it = 0; it < 10; it++) begin
      fresh = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~req_vld;
      for (int r = 0; r < NREQ; r++)
        if (fresh[r]) set_job(r, $urandom_range(0, 7), $urandom_range(0, 400));
      req_vld = req_vld | fresh;
      if (req_vld == '0) begin
        set_job(it % NREQ, 0, 0);
        req_vld[it % NREQ] = 1'b1;
      end
      serve($urandom_range(1, 3), -1, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
